// File: rtl/sdram_ports_pkg.sv
// Shared types and widths for clients of the SDRAM port arbiter.
package sdram_ports_pkg;

    localparam int unsigned SDRAM_ADDR_W = 25;
    localparam int unsigned SDRAM_DATA_W = 16;

    typedef struct packed {
        logic [SDRAM_ADDR_W-1:0] addr;
        logic [SDRAM_DATA_W-1:0] data;
    } port0_rsp_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } blit_state_t;

endpackage

// File: rtl/sdram_port0_cmd_reg.sv
// Single-entry registered Port0 command slot. A presented command is held unchanged while
// the command FIFO reports full, so it is pushed exactly once.
module sdram_port0_cmd_reg
    import sdram_ports_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    issue_rd_i,
    input  logic                    issue_wr_i,
    input  logic [SDRAM_ADDR_W-1:0] issue_addr_i,
    input  logic [SDRAM_DATA_W-1:0] issue_din_i,
    input  logic                    full_i,
    output logic                    blocked_o,
    output logic                    rdreq_o,
    output logic                    wrreq_o,
    output logic [SDRAM_ADDR_W-1:0] addr_o,
    output logic [SDRAM_DATA_W-1:0] din_o
);

    logic                    rdreq_q, rdreq_d;
    logic                    wrreq_q, wrreq_d;
    logic [SDRAM_ADDR_W-1:0] addr_q, addr_d;
    logic [SDRAM_DATA_W-1:0] din_q, din_d;

    assign blocked_o = (rdreq_q | wrreq_q) & full_i;

    always_comb begin
        rdreq_d = rdreq_q;
        wrreq_d = wrreq_q;
        addr_d  = addr_q;
        din_d   = din_q;
        if (!blocked_o) begin
            // Read wins if a caller ever asserts both, keeping the strobes exclusive.
            rdreq_d = issue_rd_i;
            wrreq_d = issue_wr_i & ~issue_rd_i;
            addr_d  = (issue_rd_i | issue_wr_i) ? issue_addr_i : '0;
            din_d   = (issue_wr_i & ~issue_rd_i) ? issue_din_i : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdreq_q <= 1'b0;
            wrreq_q <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            rdreq_q <= rdreq_d;
            wrreq_q <= wrreq_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    assign rdreq_o = rdreq_q;
    assign wrreq_o = wrreq_q;
    assign addr_o  = addr_q;
    assign din_o   = din_q;

endmodule

// File: rtl/sdram_port0_blitter.sv
// Port0 DMA blitter: copies a block of 16-bit words inside the SDRAM through the Port0
// arbiter. Reads go out in address order; responses are matched by address window.
module sdram_port0_blitter
    import sdram_ports_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 16,
    parameter int unsigned LEN_W           = 19
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [SDRAM_ADDR_W-1:0]              src_base,
    input  logic [SDRAM_ADDR_W-1:0]              dst_base,
    input  logic [LEN_W-1:0]                     length,
    output logic                                 busy,
    output logic                                 done,
    output logic [7:0]                           stray_count,
    output logic                                 port0_rdreq,
    output logic                                 port0_wrreq,
    output logic [SDRAM_ADDR_W-1:0]              port0_addr,
    output logic [SDRAM_DATA_W-1:0]              port0_din,
    input  logic                                 port0_full,
    output logic                                 port0_read,
    input  logic                                 port0_empty,
    input  logic [SDRAM_ADDR_W+SDRAM_DATA_W-1:0] port0_dout
);

    localparam int unsigned      OUT_W   = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

    blit_state_t             state_q, state_d;
    logic [SDRAM_ADDR_W-1:0] src_q, src_d;
    logic [SDRAM_ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [LEN_W-1:0]        rd_cnt_q, rd_cnt_d;
    logic [LEN_W-1:0]        wr_cnt_q, wr_cnt_d;
    logic [OUT_W-1:0]        out_q, out_d;
    logic [7:0]              stray_q, stray_d;
    logic                    read_q, read_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    issue_rd, issue_wr;
    logic [SDRAM_ADDR_W-1:0] issue_addr;
    logic [SDRAM_DATA_W-1:0] issue_din;
    logic                    cmd_blocked;

    port0_rsp_t              rsp;
    logic                    rsp_valid;
    logic [SDRAM_ADDR_W-1:0] rsp_off;
    logic                    rsp_in_win;

    assign rsp        = port0_rsp_t'(port0_dout);
    // The pop is registered, so the head is stale for the cycle its pop is in flight.
    assign rsp_valid  = ~port0_empty & ~read_q;
    assign rsp_off    = rsp.addr - src_q;
    assign rsp_in_win = rsp_off < SDRAM_ADDR_W'(len_q);

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        len_d      = len_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        out_d      = out_q;
        stray_d    = stray_q;
        read_d     = 1'b0;
        issue_rd   = 1'b0;
        issue_wr   = 1'b0;
        issue_addr = '0;
        issue_din  = '0;

        unique case (state_q)
            StIdle: begin
                read_d = rsp_valid;
                if (start) begin
                    stray_d = '0;
                    if (length != '0) begin
                        src_d    = src_base;
                        dst_d    = dst_base;
                        len_d    = length;
                        rd_cnt_d = '0;
                        wr_cnt_d = '0;
                        out_d    = '0;
                        state_d  = StRun;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StRun: begin
                if (!cmd_blocked) begin
                    if (wr_cnt_q == len_q) begin
                        state_d = StDone;
                    end else if (rsp_valid) begin
                        if (!rsp_in_win) begin
                            read_d = 1'b1;
                            if (stray_q != 8'hff) stray_d = stray_q + 8'd1;
                        end else if (!port0_full) begin
                            read_d     = 1'b1;
                            issue_wr   = 1'b1;
                            issue_addr = dst_q + rsp_off;
                            issue_din  = rsp.data;
                            wr_cnt_d   = wr_cnt_q + 1'b1;
                            // Duplicate responses must not wrap the counter below zero.
                            if (out_q != '0) out_d = out_q - 1'b1;
                        end
                    end else if (rd_cnt_q < len_q && out_q < OUT_MAX && !port0_full) begin
                        issue_rd   = 1'b1;
                        issue_addr = src_q + SDRAM_ADDR_W'(rd_cnt_q);
                        rd_cnt_d   = rd_cnt_q + 1'b1;
                        out_d      = out_q + 1'b1;
                    end
                end
            end
            StDone: begin
                read_d  = rsp_valid;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StRun);
        done_d = (state_q == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            out_q    <= '0;
            stray_q  <= '0;
            read_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            len_q    <= len_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            out_q    <= out_d;
            stray_q  <= stray_d;
            read_q   <= read_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    sdram_port0_cmd_reg u_cmd_reg (
        .clk_i       (clk),
        .rst_i       (rst),
        .issue_rd_i  (issue_rd),
        .issue_wr_i  (issue_wr),
        .issue_addr_i(issue_addr),
        .issue_din_i (issue_din),
        .full_i      (port0_full),
        .blocked_o   (cmd_blocked),
        .rdreq_o     (port0_rdreq),
        .wrreq_o     (port0_wrreq),
        .addr_o      (port0_addr),
        .din_o       (port0_din)
    );

    assign busy        = busy_q;
    assign done        = done_q;
    assign stray_count = stray_q;
    assign port0_read  = read_q;

endmodule

// File: doc/sdram_port0_blitter.md
Name: sdram_port0_blitter

Overview:
- Single-clock DMA client on the general-purpose Port0 of the SDRAM port arbiter.
- Copies LENGTH consecutive 16-bit words from a source base address to a destination base address.
- Issues Port0 read commands, consumes Port0 readout entries ({raddr, rdata}) and turns each one into a Port0 write.
- Used for frame copies and buffer moves in the frame store without CPU or pixel-path involvement. Port0 cmd and readout clocks are tied to this block's clock.

Parameters:
- MAX_OUTSTANDING, 16, maximum reads issued but not yet returned; power of two, 2..128.
- LEN_W, 19, width of the transfer-length field (2^19 > 640*480).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  pulse: begin a transfer; ignored while busy.
- src_base  in  25  first source word address; sampled on accepted start.
- dst_base  in  25  first destination word address; sampled on accepted start.
- length  in  LEN_W  number of words to copy; sampled on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the last write has been issued.
- stray_count  out  8  saturating count of discarded out-of-window readout entries; cleared on accepted start.
- port0_rdreq  out  1  push a read command.
- port0_wrreq  out  1  push a write command.
- port0_addr  out  25  command address.
- port0_din  out  16  write data; 0 for reads.
- port0_full  in  1  cmd FIFO full.
- port0_read  out  1  pop the readout FIFO.
- port0_empty  in  1  readout FIFO empty.
- port0_dout  in  41  readout head {raddr[40:16], rdata[15:0]}; show-ahead, valid when ~port0_empty.

Behaviour:
- Reset values: busy=0, done=0, stray_count=0, port0_rdreq=0, port0_wrreq=0, port0_read=0, port0_addr=0, port0_din=0. All Port0 outputs are registered, so a command appears one cycle after its decision.
- FSM states:
  - IDLE: start with length!=0 latches src, dst, len, clears counters and goes to RUN. start with length==0 goes to DONE. No start: stays in IDLE.
  - RUN: issue reads and writes until wr_cnt==len, then go to DONE.
  - DONE: done=1 for one cycle, busy=0, return to IDLE.
- Counters: rd_cnt and wr_cnt are LEN_W bits, outstanding is clog2(MAX_OUTSTANDING)+1 bits.
- At most one command per cycle, because the arbiter pushes on rdreq|wrreq. rdreq and wrreq are never both high.
- Write path has priority over the read path. In RUN, when ~port0_empty and no registered command is blocked:
  - Window test: off = raddr - src (mod 2^25). The entry is in-window iff off < len.
  - In-window and ~port0_full: port0_read=1, wrreq=1, addr=dst+off (mod 2^25), din=rdata, wr_cnt+1, outstanding-1.
  - Out-of-window: port0_read=1, entry discarded, stray_count+1 (saturate at 255), no command issued.
- Read path, taken only when the write path is idle this cycle: rd_cnt<len, outstanding<MAX_OUTSTANDING and ~port0_full give rdreq=1, addr=src+rd_cnt, rd_cnt+1, outstanding+1.
- port0_full is re-checked against the registered command. If full is seen the command is withheld; no command is ever dropped or duplicated.
- The readout FIFO may carry responses to other Port0 users. The address window filters them, and response order is not assumed.
- Duplicate in-window responses are counted as writes. Software must not share the source window with concurrent Port0 readers.
- IDLE and DONE: any readout entry is popped and discarded (counted as stray only in RUN). This drains late responses after a reset or abort.
- rst mid-transfer: return to IDLE next cycle with all outputs at reset values. In-flight read responses are drained and discarded in IDLE.
- start while busy: ignored, no state change.

Decomposition:
- Package sdram_ports_pkg:
  - SDRAM_ADDR_W=25, SDRAM_DATA_W=16.
  - typedef port0_rsp_t packed {addr[24:0], data[15:0]}.
  - Enum blit_state_t {IDLE, RUN, DONE}.
- Sub-module sdram_port0_cmd_reg: single-entry registered command slot with full-stall hold. It keeps rdreq/wrreq/addr/din stable while port0_full is high, and is shared with future Port0 clients.

Test Plan:
- Basic copy: memory model preloaded src 0x1000..0x100F = 0xA000+i; start with src=0x1000, dst=0x2000, len=16. Required: 16 rdreq then 16 wrreq, dst 0x2000+i = 0xA000+i, exactly one done pulse, stray_count=0.
- Backpressure: same transfer with port0_full held high for 10 cycles every 20. Required: no command while full is high, exactly 16 reads and 16 writes, data correct.
- Outstanding cap: model returns responses after 200 cycles, len=64. Required: outstanding never exceeds 16, and reads resume as responses arrive.
- Stray filtering: inject a readout entry with addr 0x5000 during a copy of src=0x1000, len=8. Required: it is popped and not written, stray_count=1, and the 8 correct writes complete.
- Zero length and wrap: len=0 gives done 2 cycles after start with no commands. src=0x1FFFFFE, len=4 reads 0x1FFFFFE, 0x1FFFFFF, 0x0, 0x1, and the writes map by offset.
- Reset mid-transfer: assert rst after 5 reads issued. Required: outputs at reset values the next cycle; the 5 late responses are popped in IDLE with no writes; a subsequent new transfer completes correctly.
